sr_config_driver: RTL and testbench
===================================

SR_CONFIG_DRIVER -- requirements
Module: sr_config_driver

Interface
REQ-001 SHALL have parameter BITS, default 8, config chain length in bits (>=1).
REQ-002 SHALL have parameter DIV, default 2, clk cycles per phase (>=1).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port res_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, launches a write when idle.
REQ-006 SHALL have port load_en, input, 1, sampled with start; 1 = issue ld after shifting.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of a write in progress.
REQ-008 SHALL have port wdata, input, BITS, config word, sampled with start.
REQ-009 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, BITS, previous chain contents shifted out.
REQ-012 SHALL have ports ck1, ck2, sin and ld, all outputs, 1 bit each, registered drives to the chip chain.
REQ-013 SHALL have port sout, input, 1, chain output, already synchronous to clk.

Function
REQ-014 SHALL use states IDLE, SETUP, CK1, GAP1, CK2, GAP2, LOAD and DONE, each lasting DIV clk cycles except IDLE and DONE.
REQ-015 SHALL accept start only in IDLE, latching wdata and load_en into a shift register; start while busy is ignored.
REQ-016 SHALL shift bits MSB first: bit k of the sequence drives sin = wdata[BITS-1-k], so wdata[i] ends in chain position i.
REQ-017 SHALL hold sin stable from SETUP entry through GAP2 exit of each bit.
REQ-018 SHALL assert ck1 only in CK1 and ck2 only in CK2, so ck1 and ck2 never overlap and are separated by at least DIV cycles.
REQ-019 SHALL sample sout on the first SETUP cycle of bit k into rdata[BITS-1-k].
REQ-020 SHALL go from GAP2 to SETUP while bits remain; after the last bit it SHALL go to LOAD if load_en was latched, else to DONE.
REQ-021 SHALL assert ld only in LOAD, for DIV cycles, with ck1, ck2 and sin low.
REQ-022 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; busy SHALL be high in every state other than IDLE.
REQ-023 SHALL take exactly 5*DIV*BITS + 1 cycles from start to done when load_en=0, and 5*DIV*BITS + DIV + 1 cycles when load_en=1.
REQ-024 SHALL count bits with a counter of width clog2(BITS+1) and phases with a counter of width clog2(DIV+1), with no wrap-around inside a write.
REQ-025 SHALL, on abort in any busy state, drive ck1, ck2, ld and sin low on the next cycle, return to IDLE without a done pulse, and leave rdata partially updated.
REQ-026 SHALL give abort priority over any phase transition that occurs in the same cycle; abort in IDLE has no effect.
REQ-027 SHALL hold rdata unchanged except at the sample points in REQ-019.

Reset
REQ-028 SHALL, while res_n=0, force state IDLE, ck1=0, ck2=0, sin=0, ld=0, busy=0, done=0, rdata=0 and all counters to 0, independent of clk.
REQ-029 SHALL, when reset is asserted mid-write, leave no ld pulse pending after release.
REQ-030 SHALL accept start on the first clk edge after res_n deasserts.

Structure
REQ-031 SHALL define the state enum and phase encoding in package sr_driver_pkg.
REQ-032 SHALL contain one sub-module, sr_phase_timer, which loads DIV-1, counts down and flags phase end.

Verification
REQ-033 SHALL cover: BITS=8, DIV=2, wdata=8'hA5, load_en=1 -> a receiver model's q=8'hA5, done 83 cycles after start, one ld pulse 2 cycles wide.
REQ-034 SHALL cover: chain preloaded with 8'h3C, then a write of 8'hFF -> rdata=8'h3C.
REQ-035 SHALL cover: load_en=0 -> no ld edge, receiver q unchanged, done 81 cycles after start.
REQ-036 SHALL cover: abort during bit 3 CK2 -> ck2 low next cycle, no done pulse, no ld pulse, a following start completes normally.
REQ-037 SHALL cover: res_n pulsed low during LOAD -> ld drops immediately, all outputs at reset values.
REQ-038 SHALL cover: DIV=1, BITS=1 with start held high continuously -> writes run back-to-back, every ck1/ck2 edge pair is non-overlapping, and done pulses every 7 cycles.

Source files
------------

// File: rtl/sr_driver_pkg.sv
// ---------------------------------------------------------------------------
// sr_driver_pkg
// Shared types for the two-phase shift-register configuration driver.
//   state_t   : controller states; every bit of the word walks through
//               SETUP -> CK1 -> GAP1 -> CK2 -> GAP2
//   drive_t   : the four pins driven towards the chip chain
//   isTimed   : states that last a programmable number of clk cycles
//   isBitPhase: states in which the current data bit is presented on sin
//   driveFor  : pin values that belong to a given state
// ---------------------------------------------------------------------------
package sr_driver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CK1   = 3'd2,
    GAP1  = 3'd3,
    CK2   = 3'd4,
    GAP2  = 3'd5,
    LOAD  = 3'd6,
    DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic ck1;
    logic ck2;
    logic sin;
    logic ld;
  } drive_t;

  function automatic logic isTimed(state_t s);
    return (s inside {SETUP, CK1, GAP1, CK2, GAP2, LOAD});
  endfunction

  function automatic logic isBitPhase(state_t s);
    return (s inside {SETUP, CK1, GAP1, CK2, GAP2});
  endfunction

  // The clocks and ld are pure state decodes; sin carries the data bit only
  // while a bit is being transferred so the chain sees a quiet line otherwise.
  function automatic drive_t driveFor(state_t s, logic bitVal);
    drive_t d;
    d.ck1 = (s == CK1);
    d.ck2 = (s == CK2);
    d.ld  = (s == LOAD);
    d.sin = isBitPhase(s) && bitVal;
    return d;
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// ---------------------------------------------------------------------------
// sr_phase_timer
// Down-counter that measures one controller phase of DIV clk cycles.
// Ports:
//   clk, res_n     : system clock, asynchronous active-low reset
//   i_load         : a new timed phase starts next cycle, load DIV-1
//   i_clear        : next state is untimed, park the counter at zero
//   o_phaseEnd     : current cycle is the last one of the phase
//   o_phaseFirst   : current cycle is the first one of the phase
// ---------------------------------------------------------------------------
module sr_phase_timer #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_phaseEnd,
  output logic o_phaseFirst
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  // Counter stops at zero instead of wrapping, so a phase that is not
  // followed by a reload simply reports "end" until the FSM moves on.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_phaseEnd   = (r_count == '0);
  assign o_phaseFirst = (r_count == LOAD_VAL);

endmodule

// File: rtl/sr_config_driver.sv
// ---------------------------------------------------------------------------
// sr_config_driver
// Writes a BITS-wide word MSB first into an on-chip two-phase shift chain
// (non-overlapping ck1/ck2), optionally pulses ld to transfer the chain into
// the chip's holding register, and captures the old chain contents on rdata.
// Ports:
//   clk, res_n   : system clock, asynchronous active-low reset
//   start        : launch a write (accepted in IDLE only)
//   load_en      : sampled with start, 1 = pulse ld after shifting
//   abort        : synchronous cancel of a write in progress
//   wdata        : word to write, sampled with start
//   busy, done   : write in progress / one-cycle completion pulse
//   rdata        : previous chain contents shifted out through sout
//   ck1, ck2     : two-phase chain clocks
//   sin, ld      : chain data in and load strobe
//   sout         : chain data out, already synchronous to clk
// ---------------------------------------------------------------------------
module sr_config_driver
  import sr_driver_pkg::*;
#(
  parameter int BITS = 8,
  parameter int DIV  = 2
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            start,
  input  logic            load_en,
  input  logic            abort,
  input  logic [BITS-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] rdata,
  output logic            ck1,
  output logic            ck2,
  output logic            sin,
  output logic            ld,
  input  logic            sout
);

  localparam int BW = $clog2(BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [BW-1:0]   r_bitIdx;
  logic [BITS-1:0] r_shiftReg;
  logic [BITS-1:0] w_nextShift;
  logic            r_loadEn;
  logic            r_busy;
  logic            r_done;
  drive_t          r_drive;
  logic [BITS-1:0] r_rdata;

  logic w_accept;
  logic w_abort;
  logic w_phaseEnd;
  logic w_phaseFirst;
  logic w_timerLoad;
  logic w_timerClear;
  logic w_lastBit;

  sr_phase_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk          (clk),
    .res_n        (res_n),
    .i_load       (w_timerLoad),
    .i_clear      (w_timerClear),
    .o_phaseEnd   (w_phaseEnd),
    .o_phaseFirst (w_phaseFirst)
  );

  // Next-state and next-shift-word logic. Abort overrides every phase
  // transition. The shift word advances when a bit's GAP2 ends so that its
  // MSB is always the bit currently on the chain input.
  always_comb begin
    w_accept    = (r_state == IDLE) && start;
    w_abort     = (r_state != IDLE) && abort;
    w_lastBit   = (r_bitIdx == LAST_BIT);
    w_nextState = r_state;
    w_nextShift = r_shiftReg;
    if (w_abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_nextState = SETUP;
            w_nextShift = wdata;
          end
        end
        SETUP: if (w_phaseEnd) w_nextState = CK1;
        CK1:   if (w_phaseEnd) w_nextState = GAP1;
        GAP1:  if (w_phaseEnd) w_nextState = CK2;
        CK2:   if (w_phaseEnd) w_nextState = GAP2;
        GAP2: begin
          if (w_phaseEnd) begin
            if (!w_lastBit) begin
              w_nextState = SETUP;
              w_nextShift = r_shiftReg << 1;
            end else if (r_loadEn) begin
              w_nextState = LOAD;
            end else begin
              w_nextState = DONE;
            end
          end
        end
        LOAD:    if (w_phaseEnd) w_nextState = DONE;
        DONE:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
    // Every timed state is always entered from a different state, so a state
    // change into a timed state is exactly the start of a new phase.
    w_timerLoad  = isTimed(w_nextState) && (w_nextState != r_state);
    w_timerClear = !isTimed(w_nextState);
  end

  // Controller state plus all pin drives. Outputs are registered from the
  // next state so they change together with the state and never glitch.
  // rdata takes one bit per transfer, on the first SETUP cycle of that bit,
  // which is when the chain output holds the old bit for that position.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= IDLE;
      r_bitIdx   <= '0;
      r_shiftReg <= '0;
      r_loadEn   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drive    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_shiftReg <= w_nextShift;
      if (w_accept) begin
        r_loadEn <= load_en;
        r_bitIdx <= '0;
      end else if (!w_abort && (r_state == GAP2) && w_phaseEnd && !w_lastBit) begin
        r_bitIdx <= r_bitIdx + BW'(1);
      end
      r_busy  <= (w_nextState != IDLE);
      r_done  <= (w_nextState == DONE);
      r_drive <= driveFor(w_nextState, w_nextShift[BITS-1]);
      if (!w_abort && (r_state == SETUP) && w_phaseFirst) begin
        for (int i = 0; i < BITS; i++) begin
          if (i == BITS - 1 - int'(r_bitIdx)) begin
            r_rdata[i] <= sout;
          end
        end
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign ck1   = r_drive.ck1;
  assign ck2   = r_drive.ck2;
  assign sin   = r_drive.sin;
  assign ld    = r_drive.ld;

endmodule

// File: tb/tb_sr_config_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_config_driver
// Drives directed writes into an 8-bit / DIV=2 driver connected to a small
// behavioural model of the chip chain, and runs a 1-bit / DIV=1 instance
// with start held high to exercise back-to-back writes.
// ---------------------------------------------------------------------------
module tb_sr_config_driver;

  localparam int BITS      = 8;
  localparam int DIV       = 2;
  localparam int SHIFT_CYC = 5 * DIV * BITS;

  logic            clk = 1'b0;
  logic            res_n = 1'b1;
  logic            start = 1'b0;
  logic            load_en = 1'b0;
  logic            abort = 1'b0;
  logic [BITS-1:0] wdata = '0;
  logic            busy, done, ck1, ck2, sin, ld, sout;
  logic [BITS-1:0] rdata;

  logic       start2 = 1'b0;
  logic       load2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [0:0] wdata2 = 1'b0;
  logic       sout2 = 1'b0;
  logic       busy2, done2, ck1b, ck2b, sinb, ldb;
  logic [0:0] rdata2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Chip-side chain: ck1 captures into the master stage, ck2 moves master
  // into the slave stage, ld copies the chain into the holding register.
  logic [BITS-1:0] rxMaster = '0;
  logic [BITS-1:0] rxShift = '0;
  logic [BITS-1:0] rxQ = '0;

  // Expected behaviour of the driver expressed as an offset into a write.
  bit              mActive = 1'b0;
  bit              mLoad = 1'b0;
  int              mN = 0;
  logic [BITS-1:0] mW = '0;
  logic [BITS-1:0] mSnap = '0;
  logic [BITS-1:0] mRdata = '0;

  int  startCyc = 0;
  int  ldRises = 0;
  int  ldHigh = 0;
  int  ck2Rises = 0;
  int  doneCount = 0;
  bit  ldPrev = 1'b0;
  bit  ck2Prev = 1'b0;
  bit  b2On = 1'b0;
  int  b2Last = -1;
  int  b2Dones = 0;

  sr_config_driver #(.BITS(BITS), .DIV(DIV)) dut (
    .clk(clk), .res_n(res_n), .start(start), .load_en(load_en), .abort(abort),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .ck1(ck1),
    .ck2(ck2), .sin(sin), .ld(ld), .sout(sout)
  );

  sr_config_driver #(.BITS(1), .DIV(1)) dut2 (
    .clk(clk), .res_n(res_n), .start(start2), .load_en(load2), .abort(abort2),
    .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2), .ck1(ck1b),
    .ck2(ck2b), .sin(sinb), .ld(ldb), .sout(sout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge ck1) rxMaster <= {rxShift[BITS-2:0], sin};
  always @(posedge ck2) rxShift <= rxMaster;
  always @(posedge ld) rxQ <= rxShift;
  assign sout = rxShift[BITS-1];

  // Model advance: a write lasts SHIFT_CYC cycles of bit transfer, DIV more
  // cycles of ld when requested, then one done cycle. rdata bit for transfer
  // k takes the chain's old bit at position BITS-1-k on that bit's first cycle.
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mActive <= 1'b0;
      mN      <= 0;
      mRdata  <= '0;
    end else if (mActive) begin
      if (abort) begin
        mActive <= 1'b0;
      end else begin
        if (mN <= SHIFT_CYC && ((mN - 1) % (5 * DIV)) == 0)
          mRdata[BITS-1-(mN-1)/(5*DIV)] <= mSnap[BITS-1-(mN-1)/(5*DIV)];
        if (mN == SHIFT_CYC + (mLoad ? DIV : 0) + 1) mActive <= 1'b0;
        else mN <= mN + 1;
      end
    end else if (start) begin
      mActive <= 1'b1;
      mN      <= 1;
      mW      <= wdata;
      mLoad   <= load_en;
      mSnap   <= rxShift;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock step: compare against the model on the falling edge, then
  // update the event counters used by the directed checks.
  task automatic stepCycle();
    bit eBusy, eDone, eCk1, eCk2, eSin, eLd;
    int p;
    @(negedge clk);
    if (res_n) begin
      {eBusy, eDone, eCk1, eCk2, eSin, eLd} = '0;
      if (mActive) begin
        eBusy = 1'b1;
        if (mN <= SHIFT_CYC) begin
          p    = (mN - 1) / DIV;
          eCk1 = (p % 5 == 1);
          eCk2 = (p % 5 == 3);
          eSin = mW[BITS-1-p/5];
        end else if (mN <= SHIFT_CYC + (mLoad ? DIV : 0)) begin
          eLd = 1'b1;
        end else begin
          eDone = 1'b1;
        end
      end
      checkOutput("busy", busy, eBusy);
      checkOutput("done", done, eDone);
      checkOutput("ck1", ck1, eCk1);
      checkOutput("ck2", ck2, eCk2);
      checkOutput("sin", sin, eSin);
      checkOutput("ld", ld, eLd);
      checkOutput("rdata", rdata, mRdata);
    end
    if (ld && !ldPrev) ldRises++;
    ldPrev = ld;
    if (ld) ldHigh++;
    if (ck2 && !ck2Prev) ck2Rises++;
    ck2Prev = ck2;
    if (done) doneCount++;
    if (b2On) begin
      checkOutput("b2_overlap", ck1b & ck2b, 1'b0);
      if (ck1b || ck2b) checkOutput("b2_sin", sinb, wdata2);
      if (done2) begin
        if (b2Last >= 0) checkOutput("b2_period", cyc - b2Last, 7);
        b2Last = cyc;
        b2Dones++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [BITS-1:0] w, input logic le, input logic ab);
    wdata    = w;
    load_en  = le;
    abort    = ab;
    start    = 1'b1;
    startCyc = cyc;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input string name, input int expLat);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      stepCycle();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, found, 1'b1);
    if (found) checkOutput({name, "_latency"}, cyc - startCyc, expLat);
  endtask

  task automatic checkAllReset(input string name);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_done"}, done, 1'b0);
    checkOutput({name, "_ck1"}, ck1, 1'b0);
    checkOutput({name, "_ck2"}, ck2, 1'b0);
    checkOutput({name, "_sin"}, sin, 1'b0);
    checkOutput({name, "_ld"}, ld, 1'b0);
    checkOutput({name, "_rdata"}, rdata, 8'h00);
  endtask

  initial begin
    int l0, h0, d0, c0;
    bit seen;

    // Asynchronous reset before any clock edge.
    #2 res_n = 1'b0;
    #1 checkAllReset("reset");
    stepCycle();
    stepCycle();
    res_n = 1'b1;
    stepCycle();

    // Write A5 with load: ld once, two cycles wide, receiver holds A5.
    l0 = ldRises; h0 = ldHigh;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    waitDone("a5", 83);
    stepCycle();
    checkOutput("a5_rxq", rxQ, 8'hA5);
    checkOutput("a5_ld_pulses", ldRises - l0, 1);
    checkOutput("a5_ld_width", ldHigh - h0, 2);
    checkOutput("a5_rdata", rdata, 8'h00);

    // Write 3C without load, abort raised in IDLE alongside start is ignored.
    l0 = ldRises;
    applyStimulus(8'h3C, 1'b0, 1'b1);
    waitDone("3c", 81);
    stepCycle();
    checkOutput("3c_rxq", rxQ, 8'hA5);
    checkOutput("3c_ld_pulses", ldRises - l0, 0);
    checkOutput("3c_rdata", rdata, 8'hA5);

    // Chain now holds 3C; writing FF reads it back.
    applyStimulus(8'hFF, 1'b1, 1'b0);
    waitDone("ff", 83);
    stepCycle();
    checkOutput("ff_rdata", rdata, 8'h3C);
    checkOutput("ff_rxq", rxQ, 8'hFF);

    // Abort on the last CK2 cycle of bit 3.
    d0 = doneCount; l0 = ldRises; c0 = ck2Rises;
    applyStimulus(8'h5A, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      stepCycle();
      if (ck2Rises - c0 == 4) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("abort_ck2_reached", seen, 1'b1);
    stepCycle();
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("abort_ck2_low", ck2, 1'b0);
    checkOutput("abort_busy_low", busy, 1'b0);
    for (int i = 0; i < 100; i++) stepCycle();
    checkOutput("abort_no_done", doneCount - d0, 0);
    checkOutput("abort_no_ld", ldRises - l0, 0);
    checkOutput("abort_rdata", rdata, 8'hFC);

    applyStimulus(8'h96, 1'b1, 1'b0);
    waitDone("96", 83);
    stepCycle();
    checkOutput("96_rxq", rxQ, 8'h96);
    checkOutput("96_rdata", rdata, 8'hF5);

    // Reset while ld is high, then start on the first edge after release.
    applyStimulus(8'h33, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      stepCycle();
      if (ld) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("load_reached", seen, 1'b1);
    #1 res_n = 1'b0;
    #1 checkAllReset("midload_reset");
    stepCycle();
    res_n = 1'b1;
    l0 = ldRises;
    applyStimulus(8'h81, 1'b0, 1'b0);
    waitDone("81", 81);
    stepCycle();
    checkOutput("81_no_ld", ldRises - l0, 0);

    // Back-to-back 1-bit writes with start held high.
    b2On   = 1'b1;
    wdata2 = 1'b1;
    start2 = 1'b1;
    for (int i = 0; i < 40; i++) stepCycle();
    start2 = 1'b0;
    checkOutput("b2_done_count", b2Dones, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
